// File: rtl/tt_eval_pkg.sv
// Shared types and width helper for the truth-table evaluation pipeline.
package tt_eval_pkg;

  typedef enum logic {StIdle, StSweep} state_e;

  function automatic int unsigned TT_W(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_lookup.sv
// Combinational truth-table mux shared by the eval and sweep paths.
module tt_lookup
  import tt_eval_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic [TT_W(N_IN)-1:0] tt,
  input  logic [N_IN-1:0]       idx,
  output logic                  lut_bit
);

  assign lut_bit = tt[idx];

endmodule

// File: rtl/tt_eval_pipe.sv
// Truth-table evaluator: handshaked lookup pipe, runtime table load and a self-check sweep.
module tt_eval_pipe
  import tt_eval_pkg::*;
#(
  parameter int unsigned            N_IN       = 3,
  parameter logic [TT_W(N_IN)-1:0]  DEFAULT_TT = 8'hBC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [TT_W(N_IN)-1:0] cfg_tt,
  output logic                  cfg_ready,
  input  logic                  in_valid,
  input  logic [N_IN-1:0]       in_vec,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic                  out_bit,
  input  logic                  out_ready,
  input  logic                  sweep_start,
  input  logic [TT_W(N_IN)-1:0] exp_tt,
  output logic                  sweep_busy,
  output logic                  sweep_done,
  output logic                  sweep_match,
  output logic [15:0]           eval_count
);

  localparam int unsigned   TtW     = TT_W(N_IN);
  localparam logic [N_IN:0] LastIdx = (N_IN + 1)'(TtW - 1);

  state_e            state_q, state_d;
  logic [N_IN:0]     idx_q;
  logic [TtW-1:0]    tt_q, exp_q, sweep_tt_q, sweep_tt_d;
  logic              out_valid_q, out_bit_q, match_q;
  logic [15:0]       count_q;
  logic              idle, in_fire, cfg_fire, out_fire, sweep_fire, last, lut_bit;
  logic [N_IN-1:0]   lut_idx;

  always_comb begin
    idle       = (state_q == StIdle);
    in_ready   = idle && !cfg_valid && (!out_valid_q || out_ready);
    in_fire    = in_valid && in_ready;
    cfg_fire   = cfg_valid && idle;
    out_fire   = out_valid_q && out_ready;
    sweep_fire = sweep_start && idle && !out_valid_q;
    last       = (state_q == StSweep) && (idx_q == LastIdx);
    // Sweep borrows the lookup mux; no input is accepted while it runs.
    lut_idx    = (state_q == StSweep) ? idx_q[N_IN-1:0] : in_vec;
    sweep_tt_d = sweep_tt_q;
    sweep_tt_d[lut_idx] = lut_bit;
  end

  tt_lookup #(
    .N_IN (N_IN)
  ) u_lookup (
    .tt      (tt_q),
    .idx     (lut_idx),
    .lut_bit (lut_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sweep_fire) state_d = StSweep;
      StSweep: if (last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cfg_ready   = idle;
    sweep_busy  = (state_q == StSweep);
    sweep_done  = last;
    sweep_match = match_q;
    out_valid   = out_valid_q;
    out_bit     = out_bit_q;
    eval_count  = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q        <= DEFAULT_TT;
      exp_q       <= '0;
      sweep_tt_q  <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      match_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      if (cfg_fire) tt_q <= cfg_tt;
      if (in_fire) begin
        out_valid_q <= 1'b1;
        out_bit_q   <= lut_bit;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_fire && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
      if (sweep_fire) begin
        exp_q   <= exp_tt;
        idx_q   <= '0;
        match_q <= 1'b0;
      end
      if (state_q == StSweep) begin
        sweep_tt_q <= sweep_tt_d;
        idx_q      <= idx_q + 1'b1;
        if (last) match_q <= (sweep_tt_d == exp_q);
      end
    end
  end

endmodule

// File: tb/tb_tt_eval_pipe.sv
// Scoreboard bench for tt_eval_pipe: default 3-input instance plus a 4-input instance.
module tb_tt_eval_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sweep_start = 1'b0;
  logic [7:0]  cfg_tt = '0, exp_tt = '0;
  logic [2:0]  in_vec = '0;
  logic        cfg_ready, in_ready, out_valid, out_bit, sweep_busy, sweep_done, sweep_match;
  logic [15:0] eval_count;

  logic        b_cfg_valid = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0, b_sweep_start = 1'b0;
  logic [15:0] b_cfg_tt = '0, b_exp_tt = '0;
  logic [3:0]  b_in_vec = '0;
  logic        b_cfg_ready, b_in_ready, b_out_valid, b_out_bit, b_sweep_busy, b_sweep_done;
  logic        b_sweep_match;
  logic [15:0] b_eval_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic qa[$];
  logic qb[$];
  int a_busy_cnt = 0, a_done_cnt = 0, b_busy_cnt = 0, b_done_cnt = 0;

  always #5 clk = ~clk;

  tt_eval_pipe u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_tt      (cfg_tt),
    .cfg_ready   (cfg_ready),
    .in_valid    (in_valid),
    .in_vec      (in_vec),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_bit     (out_bit),
    .out_ready   (out_ready),
    .sweep_start (sweep_start),
    .exp_tt      (exp_tt),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_match (sweep_match),
    .eval_count  (eval_count)
  );

  tt_eval_pipe #(
    .N_IN       (4),
    .DEFAULT_TT (16'h8001)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (b_cfg_valid),
    .cfg_tt      (b_cfg_tt),
    .cfg_ready   (b_cfg_ready),
    .in_valid    (b_in_valid),
    .in_vec      (b_in_vec),
    .in_ready    (b_in_ready),
    .out_valid   (b_out_valid),
    .out_bit     (b_out_bit),
    .out_ready   (b_out_ready),
    .sweep_start (b_sweep_start),
    .exp_tt      (b_exp_tt),
    .sweep_busy  (b_sweep_busy),
    .sweep_done  (b_sweep_done),
    .sweep_match (b_sweep_match),
    .eval_count  (b_eval_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected result whenever an output transfer happens.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_out", 32'(out_bit), 32'hDEAD);
      else chk("a_out_bit", 32'(out_bit), 32'(qa.pop_front()));
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_out", 32'(b_out_bit), 32'hDEAD);
      else chk("b_out_bit", 32'(b_out_bit), 32'(qb.pop_front()));
    end
    if (sweep_busy)   a_busy_cnt++;
    if (sweep_done)   a_done_cnt++;
    if (b_sweep_busy) b_busy_cnt++;
    if (b_sweep_done) b_done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qa.delete();
    qb.delete();
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Offer a vector; push its expected result once the handshake is seen (bounded).
  task automatic send_a(input logic [2:0] vec, input logic exp);
    int t = 0;
    in_valid = 1'b1;
    in_vec   = vec;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("a_send_timeout", 32'(in_ready), 32'd1);
    else qa.push_back(exp);
  endtask

  task automatic send_b(input logic [3:0] vec, input logic exp);
    int t = 0;
    b_in_valid = 1'b1;
    b_in_vec   = vec;
    @(negedge clk);
    while (!b_in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!b_in_ready) chk("b_send_timeout", 32'(b_in_ready), 32'd1);
    else qb.push_back(exp);
  endtask

  task automatic sweep_a(input logic [7:0] exp, input logic want_match);
    int b0, d0;
    step();
    sweep_start = 1'b1;
    exp_tt      = exp;
    step();
    sweep_start = 1'b0;
    exp_tt      = ~exp;
    b0 = a_busy_cnt;
    d0 = a_done_cnt;
    repeat (3) @(negedge clk);
    chk("a_sweep_in_ready", 32'(in_ready), 32'd0);
    chk("a_sweep_cfg_ready", 32'(cfg_ready), 32'd0);
    repeat (15) @(negedge clk);
    chk("a_sweep_busy_cycles", 32'(a_busy_cnt - b0), 32'd8);
    chk("a_sweep_done_pulses", 32'(a_done_cnt - d0), 32'd1);
    chk("a_sweep_match", 32'(sweep_match), 32'(want_match));
  endtask

  logic [7:0] tt_bc;
  int         d_before, b0;

  initial begin
    tt_bc = 8'hBC;
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bit", 32'(out_bit), 32'd0);
    chk("rst_eval_count", 32'(eval_count), 32'd0);
    chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    chk("rst_sweep_match", 32'(sweep_match), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Back-to-back evaluation of the default table 8'hBC.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      send_a(3'(i), tt_bc[i]);
    end
    step();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_count_after_8", 32'(eval_count), 32'd8);

    // Config wins over a simultaneous input; new table 8'h96 applies next.
    step();
    cfg_valid = 1'b1;
    cfg_tt    = 8'h96;
    in_valid  = 1'b1;
    in_vec    = 3'd5;
    @(negedge clk);
    chk("a_cfg_wins_in_ready", 32'(in_ready), 32'd0);
    chk("a_cfg_ready", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    send_a(3'd3, 1'b0);
    step();
    in_valid = 1'b0;
    step();

    // Backpressure: result held stable, no new input accepted.
    out_ready = 1'b0;
    send_a(3'd1, 1'b1);
    step();
    in_vec = 3'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("a_stall_out_valid", 32'(out_valid), 32'd1);
      chk("a_stall_out_bit", 32'(out_bit), 32'd1);
      chk("a_stall_in_ready", 32'(in_ready), 32'd0);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("a_count_after_stall", 32'(eval_count), 32'd10);
    chk("a_out_valid_drained", 32'(out_valid), 32'd0);

    // Self-check sweeps against the reset table.
    do_reset();
    sweep_a(8'hBC, 1'b1);
    sweep_a(8'hBD, 1'b0);

    // Reset mid-sweep after loading another table and counting a transfer.
    do_reset();
    step();
    cfg_valid = 1'b1;
    cfg_tt    = 8'h96;
    step();
    cfg_valid = 1'b0;
    send_a(3'd0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    sweep_start = 1'b1;
    exp_tt      = 8'h96;
    step();
    sweep_start = 1'b0;
    d_before    = a_done_cnt;
    repeat (3) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("abort_no_done", 32'(a_done_cnt - d_before), 32'd0);
    chk("abort_busy", 32'(sweep_busy), 32'd0);
    chk("abort_match", 32'(sweep_match), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_eval_count", 32'(eval_count), 32'd0);
    step();
    rst = 1'b0;
    sweep_a(8'hBC, 1'b1);

    // Reset with a pending output drops it.
    out_ready = 1'b0;
    step();
    send_a(3'd2, 1'b1);
    step();
    in_valid = 1'b0;
    do_reset();
    @(negedge clk);
    chk("drop_pending_out_valid", 32'(out_valid), 32'd0);

    // Four-input instance with table 16'h8001.
    b_out_ready = 1'b1;
    step();
    send_b(4'd15, 1'b1);
    step();
    send_b(4'd7, 1'b0);
    step();
    b_in_valid = 1'b0;
    repeat (2) step();
    b_sweep_start = 1'b1;
    b_exp_tt      = 16'h8001;
    step();
    b_sweep_start = 1'b0;
    b_exp_tt      = 16'h0000;
    b0 = b_busy_cnt;
    repeat (30) @(negedge clk);
    chk("b_sweep_busy_cycles", 32'(b_busy_cnt - b0), 32'd16);
    chk("b_sweep_match", 32'(b_sweep_match), 32'd1);
    chk("b_eval_count", 32'(b_eval_count), 32'd2);

    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
